// File: rtl/mdio_master_pkg.sv
// Shared MDIO Clause-22 constants, FSM state encoding and frame builder
// for the mdio_master controller.
package mdio_master_pkg;

  localparam logic [1:0] MDIO_ST    = 2'b01;
  localparam logic [1:0] MDIO_OP_WR = 2'b01;
  localparam logic [1:0] MDIO_OP_RD = 2'b10;
  localparam logic [1:0] MDIO_TA_WR = 2'b10;

  localparam int HDR_BITS   = 14;
  localparam int TA_BITS    = 2;
  localparam int DATA_BITS  = 16;
  localparam int FRAME_BITS = HDR_BITS + TA_BITS + DATA_BITS;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PREAMBLE,
    ST_HDR,
    ST_TA,
    ST_DATA,
    ST_DONE
  } state_e;

  // Post-preamble frame, MSB first. Read TA/DATA slots hold ones so the
  // undriven mdio_o rests at the idle level while the PHY owns the line.
  function automatic logic [FRAME_BITS-1:0] build_frame(
    input logic        write,
    input logic [4:0]  phy_addr,
    input logic [4:0]  reg_addr,
    input logic [15:0] wdata
  );
    return {MDIO_ST,
            write ? MDIO_OP_WR : MDIO_OP_RD,
            phy_addr,
            reg_addr,
            write ? MDIO_TA_WR : 2'b11,
            write ? wdata : 16'hFFFF};
  endfunction

endpackage

// File: rtl/mdio_clk_gen.sv
// MDC generator: low half then high half per bit, with one-cycle strobes on
// the cycles whose closing clk edge makes mdc rise or fall.
module mdio_clk_gen #(
  parameter int HALF_PERIOD = 12
) (
  input  logic clk_50,
  input  logic reset,
  input  logic i_run,
  output logic o_mdc,
  output logic o_fall_stb,
  output logic o_rise_stb
);

  localparam logic [7:0] HP_LAST = 8'(HALF_PERIOD - 1);

  logic [7:0] r_phase;
  logic       r_mdc;
  logic       w_wrap;

  assign w_wrap     = (r_phase == HP_LAST);
  assign o_mdc      = r_mdc;
  assign o_rise_stb = i_run & w_wrap & ~r_mdc;
  assign o_fall_stb = i_run & w_wrap & r_mdc;

  // NOTE: non-blocking assignments for all state so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk_50 or posedge reset) begin
    if (reset) begin
      r_phase <= '0;
      r_mdc   <= 1'b0;
    end else if (!i_run) begin
      r_phase <= '0;
      r_mdc   <= 1'b0;
    end else if (w_wrap) begin
      r_phase <= '0;
      r_mdc   <= ~r_mdc;
    end else begin
      r_phase <= r_phase + 8'd1;
    end
  end

endmodule

// File: rtl/mdio_master.sv
// Clause-22 MDIO master: serialises one register read/write per request into
// an MDC/MDIO frame and returns read data or a missing-PHY error flag.
module mdio_master
  import mdio_master_pkg::*;
#(
  parameter int HALF_PERIOD  = 12,
  parameter int PREAMBLE_LEN = 32
) (
  input  logic        clk_50,
  input  logic        reset,
  input  logic        enable,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [4:0]  req_phy_addr,
  input  logic [4:0]  req_reg_addr,
  input  logic [15:0] req_wdata,
  output logic        rsp_valid,
  output logic [15:0] rsp_rdata,
  output logic        rsp_err,
  output logic        mdc,
  output logic        mdio_o,
  output logic        mdio_oe,
  input  logic        mdio_i
);

  localparam logic [5:0] PRE_LAST  = (PREAMBLE_LEN == 0) ? 6'd0 : 6'(PREAMBLE_LEN - 1);
  localparam logic [5:0] HDR_LAST  = 6'(HDR_BITS - 1);
  localparam logic [5:0] TA_LAST   = 6'(TA_BITS - 1);
  localparam logic [5:0] DATA_LAST = 6'(DATA_BITS - 1);

  state_e      r_state, w_next_state;
  logic [5:0]  r_bit_cnt, w_last_idx;
  logic [31:0] r_shift;
  logic [15:0] r_rx, r_rsp_rdata;
  logic [1:0]  r_sync;
  logic        r_write, r_ta2;
  logic        r_req_ready, r_rsp_valid, r_rsp_err, r_mdio_o, r_mdio_oe;
  logic        w_run, w_fall_stb, w_rise_stb, w_accept, w_bit_done;
  logic [31:0] w_frame;

  assign req_ready = r_req_ready & enable;
  assign w_accept  = req_valid & req_ready;
  assign w_run     = r_state inside {ST_PREAMBLE, ST_HDR, ST_TA, ST_DATA};
  assign w_frame   = build_frame(req_write, req_phy_addr, req_reg_addr, req_wdata);

  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_err   = r_rsp_err;
  assign mdio_o    = r_mdio_o;
  assign mdio_oe   = r_mdio_oe;

  mdio_clk_gen #(.HALF_PERIOD(HALF_PERIOD)) u_clk_gen (
    .clk_50     (clk_50),
    .reset      (reset),
    .i_run      (w_run),
    .o_mdc      (mdc),
    .o_fall_stb (w_fall_stb),
    .o_rise_stb (w_rise_stb)
  );

  always_ff @(posedge clk_50 or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_next_state;
  end

  // NOTE: every always_comb output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    w_last_idx   = 6'd0;
    w_next_state = r_state;
    case (r_state)
      ST_PREAMBLE: w_last_idx = PRE_LAST;
      ST_HDR:      w_last_idx = HDR_LAST;
      ST_TA:       w_last_idx = TA_LAST;
      ST_DATA:     w_last_idx = DATA_LAST;
      default:     w_last_idx = 6'd0;
    endcase
    w_bit_done = w_fall_stb && (r_bit_cnt == w_last_idx);
    case (r_state)
      ST_IDLE:     if (w_accept) w_next_state = (PREAMBLE_LEN == 0) ? ST_HDR : ST_PREAMBLE;
      ST_PREAMBLE: if (w_bit_done) w_next_state = ST_HDR;
      ST_HDR:      if (w_bit_done) w_next_state = ST_TA;
      ST_TA:       if (w_bit_done) w_next_state = ST_DATA;
      ST_DATA:     if (w_bit_done) w_next_state = ST_DONE;
      ST_DONE:     w_next_state = ST_IDLE;
      default:     w_next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_50 or posedge reset) begin
    if (reset) begin
      r_sync      <= 2'b11;
      r_bit_cnt   <= '0;
      r_shift     <= '0;
      r_write     <= 1'b0;
      r_ta2       <= 1'b1;
      r_rx        <= '0;
      r_req_ready <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
      r_mdio_o    <= 1'b1;
      r_mdio_oe   <= 1'b0;
    end else begin
      r_sync      <= {r_sync[0], mdio_i};
      r_req_ready <= (w_next_state == ST_IDLE);
      r_rsp_valid <= 1'b0;

      // The first bit is launched on the accept edge so it is already on
      // the line in the first low-half cycle.
      if (w_accept) begin
        r_write   <= req_write;
        r_bit_cnt <= '0;
        r_mdio_oe <= 1'b1;
        if (PREAMBLE_LEN == 0) begin
          r_mdio_o <= w_frame[31];
          r_shift  <= {w_frame[30:0], 1'b1};
        end else begin
          r_mdio_o <= 1'b1;
          r_shift  <= w_frame;
        end
      end else if (w_fall_stb) begin
        r_bit_cnt <= (w_next_state != r_state) ? 6'd0 : r_bit_cnt + 6'd1;
        if (w_next_state == ST_DONE) begin
          r_mdio_o    <= 1'b1;
          r_mdio_oe   <= 1'b0;
          r_rsp_valid <= 1'b1;
          r_rsp_rdata <= r_write ? 16'h0000 : r_rx;
          r_rsp_err   <= ~r_write & r_ta2;
        end else if (r_state != ST_PREAMBLE || w_next_state == ST_HDR) begin
          r_mdio_o <= r_shift[31];
          r_shift  <= {r_shift[30:0], 1'b1};
          if (r_state == ST_HDR && w_next_state == ST_TA) r_mdio_oe <= r_write;
        end
      end

      if (w_rise_stb) begin
        if (r_state == ST_TA && r_bit_cnt == TA_LAST) r_ta2 <= r_sync[1];
        if (r_state == ST_DATA) r_rx <= {r_rx[14:0], r_sync[1]};
      end
    end
  end

endmodule

// File: tb/tb_mdio_master.sv
// Scoreboard bench for mdio_master: default-parameter instance with a PHY
// model, plus a fast instance (HALF_PERIOD=4, PREAMBLE_LEN=0).
module tb_mdio_master;

  typedef struct packed {
    logic [15:0] rdata;
    logic        err;
    logic [63:0] stream;
    logic [6:0]  nbits;
    logic [11:0] latency;
  } exp_t;

  localparam logic [15:0] PHY_DATA = 16'h0141;
  localparam logic [13:0] PHY_HDR  = 14'h1822;

  logic        clk_50 = 1'b0;
  logic        reset  = 1'b1;
  logic        enable = 1'b1;
  logic [1:0]  req_valid = 2'b00;
  logic        req_write = 1'b0;
  logic [4:0]  req_phy = '0, req_reg = '0;
  logic [15:0] req_wdata = '0;
  logic        phy_mdio = 1'b1;

  logic        a_ready, a_rsp_valid, a_rsp_err, a_mdc, a_mdio_o, a_mdio_oe;
  logic        b_ready, b_rsp_valid, b_rsp_err, b_mdc, b_mdio_o, b_mdio_oe;
  logic [15:0] a_rdata, b_rdata;

  logic [1:0]  rdy_v, rsp_v, err_v, mdc_v, mo_v, oe_v;
  logic [15:0] rdata_v [2];
  assign rdy_v = {b_ready, a_ready};
  assign rsp_v = {b_rsp_valid, a_rsp_valid};
  assign err_v = {b_rsp_err, a_rsp_err};
  assign mdc_v = {b_mdc, a_mdc};
  assign mo_v  = {b_mdio_o, a_mdio_o};
  assign oe_v  = {b_mdio_oe, a_mdio_oe};
  assign rdata_v[0] = a_rdata;
  assign rdata_v[1] = b_rdata;

  mdio_master dut (
    .clk_50(clk_50), .reset(reset), .enable(enable),
    .req_valid(req_valid[0]), .req_ready(a_ready), .req_write(req_write),
    .req_phy_addr(req_phy), .req_reg_addr(req_reg), .req_wdata(req_wdata),
    .rsp_valid(a_rsp_valid), .rsp_rdata(a_rdata), .rsp_err(a_rsp_err),
    .mdc(a_mdc), .mdio_o(a_mdio_o), .mdio_oe(a_mdio_oe), .mdio_i(phy_mdio)
  );

  mdio_master #(.HALF_PERIOD(4), .PREAMBLE_LEN(0)) dut_fast (
    .clk_50(clk_50), .reset(reset), .enable(enable),
    .req_valid(req_valid[1]), .req_ready(b_ready), .req_write(req_write),
    .req_phy_addr(req_phy), .req_reg_addr(req_reg), .req_wdata(req_wdata),
    .rsp_valid(b_rsp_valid), .rsp_rdata(b_rdata), .rsp_err(b_rsp_err),
    .mdc(b_mdc), .mdio_o(b_mdio_o), .mdio_oe(b_mdio_oe), .mdio_i(1'b1)
  );

  always #10 clk_50 = ~clk_50;

  int cyc = 0;
  always @(posedge clk_50) cyc <= cyc + 1;

  int n_chk = 0, n_pass = 0;
  exp_t q0[$], q1[$];
  logic [63:0] cap [2];
  int ncap [2], acc_cyc [2], last_rise [2], per_bad [2];
  logic prev_mdc [2];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual=%h required=%h", name, act, exp);
  endtask

  function automatic exp_t mk(input logic [15:0] rd, input logic er,
                              input logic [63:0] s, input int nb, input int lat);
    exp_t e;
    e.rdata = rd; e.err = er; e.stream = s; e.nbits = 7'(nb); e.latency = 12'(lat);
    return e;
  endfunction

  // Monitor: capture driven bits at each mdc rise, compare on rsp_valid.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk_50);
      for (int d = 0; d < 2; d++) begin
        if (reset) begin
          cap[d] = '0; ncap[d] = 0; last_rise[d] = -1; per_bad[d] = 0; prev_mdc[d] = 1'b0;
        end else begin
          if (req_valid[d] && rdy_v[d]) acc_cyc[d] = cyc;
          if (mdc_v[d] && !prev_mdc[d]) begin
            if (oe_v[d]) begin
              cap[d] = {cap[d][62:0], mo_v[d]};
              ncap[d]++;
            end
            if (last_rise[d] >= 0 && (cyc - last_rise[d]) != ((d == 0) ? 24 : 8)) per_bad[d]++;
            last_rise[d] = cyc;
          end
          prev_mdc[d] = mdc_v[d];
          if (rsp_v[d]) begin
            if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
              check($sformatf("d%0d_unexpected_rsp", d), 64'd1, 64'd0);
            end else begin
              if (d == 0) e = q0.pop_front();
              else        e = q1.pop_front();
              check($sformatf("d%0d_rdata", d),   64'(rdata_v[d]), 64'(e.rdata));
              check($sformatf("d%0d_err", d),     64'(err_v[d]), 64'(e.err));
              check($sformatf("d%0d_latency", d), 64'(cyc - acc_cyc[d]), 64'(e.latency));
              check($sformatf("d%0d_nbits", d),   64'(ncap[d]), 64'(e.nbits));
              check($sformatf("d%0d_stream", d),  cap[d], e.stream);
              check($sformatf("d%0d_mdc_period", d), 64'(per_bad[d]), 64'd0);
            end
            cap[d] = '0; ncap[d] = 0; last_rise[d] = -1; per_bad[d] = 0;
          end
        end
      end
    end
  end

  // PHY model at address 1: answers reads of register 2, driving on mdc fall.
  initial begin
    logic [13:0] phy_sh;
    int          phy_k;
    logic        p_mdc, p_oe;
    phy_sh = '0; phy_k = -1; p_mdc = 1'b0; p_oe = 1'b0;
    forever begin
      @(negedge clk_50);
      if (reset) begin
        phy_sh = '0; phy_k = -1; phy_mdio = 1'b1; p_mdc = 1'b0; p_oe = 1'b0;
      end else begin
        if (a_mdc && !p_mdc && a_mdio_oe) phy_sh = {phy_sh[12:0], a_mdio_o};
        if (!a_mdc && p_mdc) begin
          if (phy_k >= 0) phy_k++;
          else if (!a_mdio_oe && p_oe && phy_sh == PHY_HDR) phy_k = 0;
          if (phy_k == 1)                    phy_mdio = 1'b0;
          else if (phy_k >= 2 && phy_k <= 17) phy_mdio = PHY_DATA[17 - phy_k];
          else                               phy_mdio = 1'b1;
          if (phy_k >= 18) phy_k = -1;
        end
        p_mdc = a_mdc; p_oe = a_mdio_oe;
      end
    end
  end

  task automatic check_reset(input int d, input string name);
    check(name, 64'({rdy_v[d], rsp_v[d], rdata_v[d], err_v[d], mdc_v[d], mo_v[d], oe_v[d]}),
          64'({1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0}));
  endtask

  task automatic issue(input int d, input logic w, input logic [4:0] phy, input logic [4:0] ra,
                       input logic [15:0] wd, input exp_t e);
    bit ok = 1'b0;
    if (d == 0) q0.push_back(e);
    else        q1.push_back(e);
    @(posedge clk_50); #1;
    req_write = w; req_phy = phy; req_reg = ra; req_wdata = wd; req_valid[d] = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk_50);
      if (rdy_v[d]) begin ok = 1'b1; break; end
    end
    if (!ok) check("accept_timeout", 64'd0, 64'd1);
    @(posedge clk_50); #1;
    req_valid[d] = 1'b0;
  endtask

  task automatic wait_done(input int d);
    bit ok = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk_50);
      if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin ok = 1'b1; break; end
    end
    if (!ok) check("rsp_timeout", 64'd0, 64'd1);
    repeat (3) @(posedge clk_50);
  endtask

  initial begin
    int early, rc, ac, act;
    bit ok;

    repeat (4) @(posedge clk_50);
    #1;
    check_reset(0, "reset_values");
    check_reset(1, "reset_values_fast");
    reset = 1'b0;
    repeat (2) @(posedge clk_50);

    // Write 0x1140 to PHY 0 reg 0.
    issue(0, 1'b1, 5'h00, 5'h00, 16'h1140,
          mk(16'h0000, 1'b0, {32'hFFFF_FFFF, 32'h5002_1140}, 64, 1537));
    wait_done(0);

    // Read PHY 1 reg 2, answered by the model.
    issue(0, 1'b0, 5'h01, 5'h02, 16'h0000,
          mk(16'h0141, 1'b0, {18'd0, 32'hFFFF_FFFF, 14'h1822}, 46, 1537));
    wait_done(0);

    // Read from an absent PHY: line stays pulled up.
    issue(0, 1'b0, 5'h03, 5'h04, 16'h0000,
          mk(16'hFFFF, 1'b1, {18'd0, 32'hFFFF_FFFF, 14'h1864}, 46, 1537));
    wait_done(0);

    // Back-to-back: req_valid held across two requests.
    q0.push_back(mk(16'h0000, 1'b0, {32'hFFFF_FFFF, 32'h510E_BEEF}, 64, 1537));
    q0.push_back(mk(16'h0000, 1'b0, {32'hFFFF_FFFF, 32'h5112_0001}, 64, 1537));
    @(posedge clk_50); #1;
    req_write = 1'b1; req_phy = 5'h02; req_reg = 5'h03; req_wdata = 16'hBEEF; req_valid[0] = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk_50);
      if (a_ready) begin ok = 1'b1; break; end
    end
    check("b2b_first_accept", 64'(ok), 64'd1);
    @(posedge clk_50); #1;
    req_reg = 5'h04; req_wdata = 16'h0001;
    early = 0; rc = -1; ac = -1;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk_50);
      if (a_rsp_valid && rc < 0) rc = cyc;
      else if (a_ready) begin
        if (rc < 0) early++;
        else begin ac = cyc; break; end
      end
    end
    @(posedge clk_50); #1;
    req_valid[0] = 1'b0;
    check("b2b_ready_low_in_frame", 64'(early), 64'd0);
    check("b2b_accept_gap", 64'(ac - rc), 64'd1);
    wait_done(0);

    // enable low: requests are ignored and the bus stays idle.
    @(posedge clk_50); #1;
    enable = 1'b0; req_write = 1'b1; req_phy = 5'h07; req_reg = 5'h07; req_valid[0] = 1'b1;
    act = 0;
    repeat (100) begin
      @(negedge clk_50);
      if (a_mdc || a_ready || a_mdio_oe) act++;
    end
    @(posedge clk_50); #1;
    req_valid[0] = 1'b0; enable = 1'b1;
    check("enable_low_idle", 64'(act), 64'd0);
    repeat (3) @(posedge clk_50);

    // Reset during DATA bit 5 of a write, then a clean write afterwards.
    issue(0, 1'b1, 5'h00, 5'h01, 16'h1234,
          mk(16'h0000, 1'b0, {32'hFFFF_FFFF, 32'h5006_1234}, 64, 1537));
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk_50);
      if (ncap[0] >= 54) begin ok = 1'b1; break; end
    end
    check("reach_data_bit5", 64'(ok), 64'd1);
    #2 reset = 1'b1;
    #1 check_reset(0, "async_reset_midframe");
    void'(q0.pop_back());
    repeat (3) @(posedge clk_50);
    #1 reset = 1'b0;
    repeat (2) @(posedge clk_50);
    issue(0, 1'b1, 5'h00, 5'h01, 16'h1234,
          mk(16'h0000, 1'b0, {32'hFFFF_FFFF, 32'h5006_1234}, 64, 1537));
    wait_done(0);

    // Fast instance: no preamble, 8-cycle mdc.
    issue(1, 1'b1, 5'h1F, 5'h10, 16'hA5C3,
          mk(16'h0000, 1'b0, {32'd0, 32'h5FC2_A5C3}, 32, 257));
    wait_done(1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
